mmio_timer: RTL and testbench

Memory-mapped machine timer that responds on the core's data-memory port (DM_addr / DM_writeData / DM_writeEnable / DM_readEnable) and is the responder side of the loads and stores the core issues. It holds the RISC-V machine timer registers mtime, mtimecmp and msip, plus a tick prescaler. It drives the machine timer (MTIP) and software (MSIP) interrupt lines into the exception controller's interrupt inputs. It sits beside the data RAM, and the top level muxes its read data onto DM_readData using rdHit.

---
 rtl/mmio_timer.sv | 125 ++++++++++++
 tb/tb_mmio_timer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// RISC-V machine timer (msip, mtimecmp, mtime, prescale) on the core's data-memory port.
// Loads return one cycle later with rdHit; stores take effect on the edge ending the store cycle.
module mmio_timer #(
    parameter int          N            = 64,
    parameter logic [N-1:0] BASE         = 64'h0000_0000_0000_2000,
    parameter logic [31:0] PRESCALE_RST = 32'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] rdData,
    output logic         rdHit,
    output logic         mtip,
    output logic         msip
);

    localparam logic [1:0] OFF_MSIP     = 2'd0;
    localparam logic [1:0] OFF_MTIMECMP = 2'd1;
    localparam logic [1:0] OFF_MTIME    = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;
    localparam logic [N-1:0] ONE_N      = {{(N-1){1'b0}}, 1'b1};

    // Strobe semantics: DM_writeEnable / DM_readEnable are single-cycle strobes with no
    // back-pressure; every strobed cycle is one access, and loads may issue every cycle.
    logic [N-1:0] r_mtime;
    logic [N-1:0] r_mtimecmp;
    logic         r_msip;
    logic [31:0]  r_prescale;
    logic [31:0]  r_div;
    logic [N-1:0] r_rd_data;
    logic         r_rd_hit;
    logic         r_mtip;

    logic         w_hit;
    logic [1:0]   w_sel;
    logic         w_tick;
    logic         w_wr_msip;
    logic         w_wr_mtimecmp;
    logic         w_wr_mtime;
    logic         w_wr_prescale;
    logic [N-1:0] w_rd_val;
    logic         w_unused;

    assign w_hit  = (DM_addr[N-1:5] == BASE[N-1:5]);
    assign w_sel  = DM_addr[4:3];
    assign w_tick = (r_div == r_prescale);

    assign w_wr_msip     = DM_writeEnable && w_hit && (w_sel == OFF_MSIP);
    assign w_wr_mtimecmp = DM_writeEnable && w_hit && (w_sel == OFF_MTIMECMP);
    assign w_wr_mtime    = DM_writeEnable && w_hit && (w_sel == OFF_MTIME);
    assign w_wr_prescale = DM_writeEnable && w_hit && (w_sel == OFF_PRESCALE);

    // Byte offset within a doubleword carries no meaning: all accesses are full width.
    assign w_unused = ^DM_addr[2:0];

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            OFF_MSIP:     w_rd_val = {{(N-1){1'b0}}, r_msip};
            OFF_MTIMECMP: w_rd_val = r_mtimecmp;
            OFF_MTIME:    w_rd_val = r_mtime;
            OFF_PRESCALE: w_rd_val = {{(N-32){1'b0}}, r_prescale};
            default:      w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= '1;
        end else begin
            if (w_wr_msip)     r_msip     <= DM_writeData[0];
            if (w_wr_mtimecmp) r_mtimecmp <= DM_writeData;
        end
    end

    // A software write to mtime beats a tick landing on the same edge; that tick is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime    <= '0;
            r_prescale <= PRESCALE_RST;
            r_div      <= 32'd0;
        end else begin
            if (w_wr_mtime) begin
                r_mtime <= DM_writeData;
            end else if (w_tick) begin
                r_mtime <= r_mtime + ONE_N;
            end

            if (w_wr_prescale) begin
                r_prescale <= DM_writeData[31:0];
                r_div      <= 32'd0;
            end else if (w_tick) begin
                r_div <= 32'd0;
            end else begin
                r_div <= r_div + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtip    <= 1'b0;
            r_rd_hit  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
            if (DM_readEnable) begin
                r_rd_hit  <= w_hit;
                r_rd_data <= w_hit ? w_rd_val : '0;
            end else begin
                r_rd_hit  <= 1'b0;
            end
        end
    end

    assign rdData = r_rd_data;
    assign rdHit  = r_rd_hit;
    assign mtip   = r_mtip;
    assign msip   = r_msip;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: inputs change on the falling edge, outputs are
// sampled on the next falling edge, load results go through an expected queue.
module tb_mmio_timer;
    localparam int N = 64;
    localparam logic [N-1:0] BASE = 64'h0000_0000_0000_2000;
    localparam logic [N-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] rdData;
    logic         rdHit;
    logic         mtip;
    logic         msip;

    int tests_run    = 0;
    int tests_failed = 0;

    // {rdHit, rdData} expected for each issued load
    logic [N:0] exp_q[$];

    mmio_timer #(
        .N(N),
        .BASE(BASE),
        .PRESCALE_RST(32'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .DM_addr(DM_addr),
        .DM_writeData(DM_writeData),
        .DM_writeEnable(DM_writeEnable),
        .DM_readEnable(DM_readEnable),
        .rdData(rdData),
        .rdHit(rdHit),
        .mtip(mtip),
        .msip(msip)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic drive(input logic we, input logic re, input logic [N-1:0] addr,
                         input logic [N-1:0] data);
        DM_writeEnable = we;
        DM_readEnable  = re;
        DM_addr        = addr;
        DM_writeData   = data;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [N:0] e;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        tests_run++;
        if (rdHit !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rdhit: got %b, expected 0", rdHit);
        end
        tests_run++;
        if (rdData !== '0) begin
            tests_failed++; $display("FAIL reset_rddata: got %h, expected 0", rdData);
        end
        tests_run++;
        if (mtip !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mtip: got %b, expected 0", mtip);
        end
        tests_run++;
        if (msip !== 1'b0) begin
            tests_failed++; $display("FAIL reset_msip: got %b, expected 0", msip);
        end
        reset = 1'b0;
        // loads straight after release: mtime 0, mtimecmp all ones, mtime 2, prescale 0, msip 0
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL reset_mtime0: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE + 64'd8, '0); exp_q.push_back({1'b1, ONES});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL reset_mtimecmp: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd2});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL reset_mtime_run: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE + 64'd24, '0); exp_q.push_back({1'b1, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL reset_prescale: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE, '0); exp_q.push_back({1'b1, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL reset_msip_reg: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive_idle();
    endtask

    task automatic test_mtip_compare();
        logic exp_mtip;
        drive(1'b1, 1'b0, BASE + 64'd16, 64'd0); edge_step();   // mtime = 0
        drive(1'b1, 1'b0, BASE + 64'd8, 64'd5); edge_step();    // mtimecmp = 5, mtime = 1
        drive_idle();
        for (int k = 2; k <= 8; k++) begin
            edge_step();
            exp_mtip = ((k - 1) >= 5);
            tests_run++;
            if (mtip !== exp_mtip) begin
                tests_failed++; $display("FAIL mtip_rise_edge%0d: got %b, expected %b", k, mtip, exp_mtip);
            end
        end
        drive(1'b1, 1'b0, BASE + 64'd8, 64'd100); edge_step();
        tests_run++;
        if (mtip !== 1'b1) begin
            tests_failed++; $display("FAIL mtip_lag_after_cmp_write: got %b, expected 1", mtip);
        end
        drive_idle(); edge_step();
        tests_run++;
        if (mtip !== 1'b0) begin
            tests_failed++; $display("FAIL mtip_drop: got %b, expected 0", mtip);
        end
    endtask

    task automatic test_back_to_back();
        logic [N:0] e;
        logic [N-1:0] v;
        drive(1'b1, 1'b0, BASE + 64'd16, 64'd0); edge_step();   // mtime = 0, tick dropped
        drive(1'b1, 1'b0, BASE + 64'd24, 64'd3); edge_step();   // last prescale-0 tick -> mtime = 1
        for (int j = 0; j < 12; j++) begin
            v = 64'(1 + j / 4);
            drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, v});
            edge_step(); e = exp_q.pop_front(); tests_run++;
            if ({rdHit, rdData} !== e) begin
                tests_failed++; $display("FAIL b2b_load%0d: got hit=%b data=%h, expected hit=%b data=%h", j, rdHit, rdData, e[N], e[N-1:0]);
            end
        end
        drive_idle(); edge_step();
        tests_run++;
        if ({rdHit, rdData} !== {1'b0, 64'd3}) begin
            tests_failed++; $display("FAIL rd_hold_idle: got hit=%b data=%h, expected hit=0 data=3", rdHit, rdData);
        end
    endtask

    task automatic test_wrap();
        logic [N:0] e;
        drive(1'b1, 1'b0, BASE + 64'd24, 64'd0); edge_step();
        drive(1'b1, 1'b0, BASE + 64'd8, ONES); edge_step();
        drive(1'b1, 1'b0, BASE + 64'd16, 64'hFFFF_FFFF_FFFF_FFFE); edge_step();
        drive_idle(); edge_step();
        tests_run++;
        if (mtip !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_mtip_before: got %b, expected 0", mtip);
        end
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, ONES});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL wrap_mtime_max: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        tests_run++;
        if (mtip !== 1'b1) begin
            tests_failed++; $display("FAIL wrap_mtip_at_max: got %b, expected 1", mtip);
        end
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL wrap_mtime_zero: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        tests_run++;
        if (mtip !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_mtip_after: got %b, expected 0", mtip);
        end
        drive_idle();
    endtask

    task automatic test_msip_and_miss();
        logic [N:0] e;
        drive(1'b1, 1'b0, BASE, ONES); edge_step();
        tests_run++;
        if (msip !== 1'b1) begin
            tests_failed++; $display("FAIL msip_set: got %b, expected 1", msip);
        end
        drive(1'b0, 1'b1, BASE, '0); exp_q.push_back({1'b1, 64'd1});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL msip_readback: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b1, 1'b0, BASE + 64'd32, 64'd0); edge_step();
        tests_run++;
        if (msip !== 1'b1) begin
            tests_failed++; $display("FAIL miss_store_ignored: got msip %b, expected 1", msip);
        end
        drive(1'b0, 1'b1, BASE + 64'd32, '0); exp_q.push_back({1'b0, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL miss_load: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b1, 1'b0, BASE + 64'd24, 64'h1234_5678_0000_0000); edge_step();
        drive(1'b0, 1'b1, BASE + 64'd24, '0); exp_q.push_back({1'b1, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL prescale_upper_zero: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b1, 1'b0, BASE + 64'd4, 64'd0); edge_step();   // low address bits ignored
        tests_run++;
        if (msip !== 1'b0) begin
            tests_failed++; $display("FAIL msip_clear: got %b, expected 0", msip);
        end
        drive_idle();
    endtask

    task automatic test_collisions();
        logic [N:0] e;
        drive(1'b1, 1'b0, BASE + 64'd16, 64'd42); edge_step();
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd42});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL write_beats_tick: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b1, 1'b1, BASE + 64'd8, 64'hCAFE); exp_q.push_back({1'b1, ONES});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL rw_same_old: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE + 64'd8, '0); exp_q.push_back({1'b1, 64'hCAFE});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL rw_same_new: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        // prescale rewrite mid-count restarts the divider
        drive(1'b1, 1'b0, BASE + 64'd16, 64'd0); edge_step();
        drive(1'b1, 1'b0, BASE + 64'd24, 64'd2); edge_step();
        drive_idle(); repeat (4) edge_step();
        drive(1'b1, 1'b0, BASE + 64'd24, 64'd2); edge_step();
        drive_idle(); repeat (2) edge_step();
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd2});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL div_restart_before: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd3});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL div_restart_after: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        logic [N:0] e;
        drive(1'b1, 1'b0, BASE, 64'd1); edge_step();
        drive(1'b1, 1'b0, BASE + 64'd8, 64'd0); edge_step();
        drive(1'b0, 1'b1, BASE, '0); exp_q.push_back({1'b1, 64'd1});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL pre_reset_load: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        tests_run++;
        if (mtip !== 1'b1) begin
            tests_failed++; $display("FAIL pre_reset_mtip: got %b, expected 1", mtip);
        end
        drive_idle();
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({rdHit, rdData, mtip, msip} !== {1'b0, 64'd0, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL async_reset: got hit=%b data=%h mtip=%b msip=%b, expected all 0", rdHit, rdData, mtip, msip);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, BASE + 64'd16, '0); exp_q.push_back({1'b1, 64'd0});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL post_reset_mtime: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive(1'b0, 1'b1, BASE + 64'd8, '0); exp_q.push_back({1'b1, ONES});
        edge_step(); e = exp_q.pop_front(); tests_run++;
        if ({rdHit, rdData} !== e) begin
            tests_failed++; $display("FAIL post_reset_mtimecmp: got hit=%b data=%h, expected hit=%b data=%h", rdHit, rdData, e[N], e[N-1:0]);
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_mtip_compare();
        test_back_to_back();
        test_wrap();
        test_msip_and_miss();
        test_collisions();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
